// File: rtl/tvsync_sep.sv
// tvsync_sep -- composite-sync separator and timing recovery for a
// 512-pixel x 312-line PAL-style composite sync.
//
// Samples an active-low composite sync and classifies each low pulse by
// its width in pixel ticks. Hsyncs re-phase a free-running pixel counter,
// the second broad pulse of a run re-phases the line counter, and a
// HUNT/LOCKED state machine reports horizontal lock.
//
// Optional build macro: TVSYNC_GLITCH_FILTER_EN adds a 3-sample majority
// filter at clk_in rate behind the synchronizer. It rejects lows shorter
// than 2 clk_in cycles and adds 1 clk_in cycle of latency.
//
// Ports:
//   clk_in     in   system clock
//   rst        in   synchronous active-high reset
//   sync_in    in   composite sync, asynchronous, 0 = sync level
//   pixel_tick out  1-cycle enable, once every PRESCALE clk_in cycles
//   cntHS      out  recovered pixel position, 0..511
//   cntVS      out  recovered line number, 0..311
//   hs_pulse   out  one pixel tick wide, on each accepted hsync
//   vs_pulse   out  one pixel tick wide, on field detection
//   vbl        out  1 when cntVS < 5 or cntVS >= 309
//   locked     out  horizontal lock indicator
module tvsync_sep #(
    parameter int PRESCALE  = 3,
    parameter int LOCK_GOOD = 8,
    parameter int LOCK_BAD  = 4,
    parameter int H_TOL     = 2
) (
    input  logic       clk_in,
    input  logic       rst,
    input  logic       sync_in,
    output logic       pixel_tick,
    output logic [8:0] cntHS,
    output logic [8:0] cntVS,
    output logic       hs_pulse,
    output logic       vs_pulse,
    output logic       vbl,
    output logic       locked
);
    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [0:0] HUNT   = 1'b0;
    localparam logic [0:0] LOCKED = 1'b1;

    function automatic logic [8:0] sat_inc9(input logic [8:0] v);
        return (v == 9'd511) ? v : v + 9'd1;
    endfunction

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    logic [PW-1:0] pre_q;
    logic          tick_q;
    logic          meta_q, sync_q;
    logic          s_in;

    // Prescaler: tick_q is a registered strobe one cycle after terminal count.
    always_ff @(posedge clk_in) begin
        if (rst) begin
            pre_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            pre_q  <= (pre_q == PW'(PRESCALE - 1)) ? '0 : pre_q + PW'(1);
            tick_q <= (pre_q == PW'(PRESCALE - 1));
        end
    end

    // Input synchronizer; idles at the non-sync level.
    always_ff @(posedge clk_in) begin
        if (rst) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
        end else begin
            meta_q <= sync_in;
            sync_q <= meta_q;
        end
    end

`ifdef TVSYNC_GLITCH_FILTER_EN
    logic h1_q, h2_q;
    always_ff @(posedge clk_in) begin
        if (rst) begin
            h1_q <= 1'b1;
            h2_q <= 1'b1;
        end else begin
            h1_q <= sync_q;
            h2_q <= h1_q;
        end
    end
    // Majority over the last three synchronized samples: a single-cycle low
    // never wins a vote, and the centre tap sets the one-cycle delay.
    assign s_in = (sync_q & h1_q) | (sync_q & h2_q) | (h1_q & h2_q);
`else
    assign s_in = sync_q;
`endif

    logic       s_q, s_d;
    logic [8:0] w_q, w_d;
    logic [8:0] hs_q, hs_d;
    logic [8:0] vs_q, vs_d;
    logic [9:0] tmo_q, tmo_d;
    logic [1:0] run_q, run_d;
    logic [7:0] good_q, good_d, bad_q, bad_d;
    logic [0:0] st_q, st_d;
    logic       have_ph_q, have_ph_d;
    logic       hsp_q, hsp_d, vsp_q, vsp_d, vbl_q, vbl_d;

    logic       rise;
    logic       is_eq, is_hs, is_inv, is_broad;
    logic [8:0] step, diff;
    logic       ph_ok, hs_good, hs_load, tmo_hit, miss, field;

    always_comb begin
        s_d = s_q;  w_d = w_q;  hs_d = hs_q;  vs_d = vs_q;
        tmo_d = tmo_q;  run_d = run_q;  good_d = good_q;  bad_d = bad_q;
        st_d = st_q;  have_ph_d = have_ph_q;
        hsp_d = hsp_q;  vsp_d = vsp_q;  vbl_d = vbl_q;
        rise = 1'b0;  is_eq = 1'b0;  is_hs = 1'b0;  is_inv = 1'b0;  is_broad = 1'b0;
        step = hs_q + 9'd1;
        diff = step - w_q;
        ph_ok = (int'(diff) <= H_TOL) || (int'(diff) >= 512 - H_TOL);
        hs_good = 1'b0;  hs_load = 1'b0;  tmo_hit = 1'b0;  miss = 1'b0;  field = 1'b0;

        if (tick_q) begin
            s_d   = s_in;
            hsp_d = 1'b0;
            vsp_d = 1'b0;
            rise  = !s_q && s_in;

            // The falling-edge tick is itself the first low tick, so W ends
            // up equal to the number of low samples.
            if (s_q && !s_in)
                w_d = 9'd1;
            else if (!s_q && !s_in)
                w_d = sat_inc9(w_q);

            if (rise) begin
                is_eq    = (w_q >= 9'd8)   && (w_q <= 9'd24);
                is_hs    = (w_q >= 9'd25)  && (w_q <= 9'd63);
                is_inv   = (w_q >= 9'd64)  && (w_q <= 9'd127);
                is_broad = (w_q >= 9'd128);
            end

            // With no phase reference yet (after reset) the first hsync
            // defines phase and counts as good. In LOCKED an off-phase hsync
            // is a miss and is not loaded, so a phase step costs LOCK_BAD
            // lines before HUNT re-acquires.
            hs_good = is_hs && (ph_ok || !have_ph_q);
            hs_load = is_hs && ((st_q == HUNT) || ph_ok);

            if (is_hs || is_broad)
                tmo_d = '0;
            else if (tmo_q == 10'd1023) begin
                tmo_d   = '0;
                tmo_hit = 1'b1;
            end else
                tmo_d = tmo_q + 10'd1;

            miss = (is_hs && !hs_good) || is_inv || tmo_hit;

            if (is_broad)
                run_d = (run_q == 2'd3) ? run_q : run_q + 2'd1;
            else if (is_eq || is_hs || is_inv)
                run_d = '0;
            field = is_broad && (run_q == 2'd1);

            if (field) begin
                hs_d  = 9'd256 + w_q;
                vs_d  = '0;
                vsp_d = 1'b1;
            end else if (hs_load) begin
                hs_d      = w_q;
                hsp_d     = 1'b1;
                have_ph_d = 1'b1;
            end else begin
                hs_d = step;
                if (hs_q == 9'd511)
                    vs_d = (vs_q == 9'd311) ? 9'd0 : vs_q + 9'd1;
            end
            vbl_d = (vs_d < 9'd5) || (vs_d >= 9'd309);

            if (st_q == HUNT) begin
                if (hs_good) begin
                    if (good_q >= 8'(LOCK_GOOD - 1)) begin
                        st_d   = LOCKED;
                        good_d = '0;
                        bad_d  = '0;
                    end else
                        good_d = sat_inc8(good_q);
                end else if (miss)
                    good_d = '0;
            end else begin
                if (miss) begin
                    if (bad_q >= 8'(LOCK_BAD - 1)) begin
                        st_d   = HUNT;
                        good_d = '0;
                        bad_d  = '0;
                    end else
                        bad_d = sat_inc8(bad_q);
                end else if (hs_good)
                    bad_d = '0;
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst) begin
            s_q <= 1'b1;  w_q <= '0;  hs_q <= '0;  vs_q <= '0;
            tmo_q <= '0;  run_q <= '0;  good_q <= '0;  bad_q <= '0;
            st_q <= HUNT;  have_ph_q <= 1'b0;
            hsp_q <= 1'b0;  vsp_q <= 1'b0;  vbl_q <= 1'b1;
        end else begin
            s_q <= s_d;  w_q <= w_d;  hs_q <= hs_d;  vs_q <= vs_d;
            tmo_q <= tmo_d;  run_q <= run_d;  good_q <= good_d;  bad_q <= bad_d;
            st_q <= st_d;  have_ph_q <= have_ph_d;
            hsp_q <= hsp_d;  vsp_q <= vsp_d;  vbl_q <= vbl_d;
        end
    end

    assign pixel_tick = tick_q;
    assign cntHS      = hs_q;
    assign cntVS      = vs_q;
    assign hs_pulse   = hsp_q;
    assign vs_pulse   = vsp_q;
    assign vbl        = vbl_q;
    assign locked     = (st_q == LOCKED);
endmodule
